// File: rtl/h264frombytes.sv
// Byte-to-bit reader for NAL payloads: strips emulation-prevention bytes, keeps an
// MSB-aligned bit window, and decodes the Exp-Golomb codeword at the window head.
module h264frombytes #(
  parameter int WINBITS  = 32,
  parameter int SHOWBITS = 24
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                NEWSLICE,
  input  logic [7:0]          BYTE,
  input  logic                STROBE,
  output logic                READY,
  output logic [SHOWBITS-1:0] BITS,
  output logic [5:0]          AVAIL,
  input  logic                ADV,
  input  logic [4:0]          ADVL,
  output logic                UEOK,
  output logic [15:0]         UEVAL,
  output logic [15:0]         SEVAL,
  output logic [4:0]          UELEN,
  output logic                ERR
);

  logic [WINBITS-1:0] window_q, window_d;
  logic [5:0]         avail_q, avail_d;
  logic [1:0]         zc_q, zc_d;
  logic               err_q, err_d;

  logic               accept, discard, append, adv_ok;
  logic [5:0]         adv_amt, rem;

  assign READY   = (avail_q <= 6'(WINBITS - 8)) && !NEWSLICE;
  assign accept  = STROBE && READY;
  assign discard = accept && (zc_q == 2'd2) && (BYTE == 8'h03);
  assign append  = accept && !discard;
  assign adv_ok  = ADV && ({1'b0, ADVL} <= avail_q);
  assign adv_amt = adv_ok ? {1'b0, ADVL} : 6'd0;
  assign rem     = avail_q - adv_amt;

  always_comb begin
    window_d = window_q << adv_amt;
    avail_d  = rem;
    zc_d     = zc_q;
    err_d    = err_q | (ADV && !adv_ok);
    if (append) begin
      // New byte lands directly below the bits still valid after this cycle's shift.
      window_d = window_d | ({{(WINBITS-8){1'b0}}, BYTE} << (6'(WINBITS - 8) - rem));
      avail_d  = rem + 6'd8;
      zc_d     = (BYTE != 8'h00) ? 2'd0 : (zc_q == 2'd2) ? 2'd2 : zc_q + 2'd1;
    end else if (discard) begin
      zc_d = 2'd0;
    end
    if (NEWSLICE) begin
      window_d = '0;
      avail_d  = 6'd0;
      zc_d     = 2'd0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      window_q <= '0;
      avail_q  <= 6'd0;
      zc_q     <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      window_q <= window_d;
      avail_q  <= avail_d;
      zc_q     <= zc_d;
      err_q    <= err_d;
    end
  end

  assign BITS  = window_q[WINBITS-1 -: SHOWBITS];
  assign AVAIL = avail_q;
  assign ERR   = err_q;

  logic [4:0]  lz;
  logic        lz_ok;
  logic [15:0] code, ueval, half;

  always_comb begin
    lz = 5'(SHOWBITS);
    for (int i = 0; i < SHOWBITS; i++) begin
      if (BITS[i]) lz = 5'(SHOWBITS - 1 - i);
    end
  end

  assign lz_ok = (lz <= 5'd11);
  assign UEOK  = lz_ok && (avail_q >= {lz, 1'b1});

  // Shifting the head down by SHOWBITS-1-2*lz leaves the lz+1 info bits, leading 1 included.
  always_comb begin
    code = 16'd0;
    if (lz_ok) code = 16'(BITS >> (5'(SHOWBITS - 1) - {lz[3:0], 1'b0}));
  end

  assign ueval = lz_ok ? code - 16'd1 : 16'd0;
  assign half  = {1'b0, ueval[15:1]};
  assign UEVAL = ueval;
  assign SEVAL = ueval[0] ? half + 16'd1 : -half;
  assign UELEN = lz_ok ? {lz[3:0], 1'b1} : 5'd1;

endmodule

// File: doc/h264frombytes.md
Name: h264frombytes

Overview:
- Bitstream-side reader that inverts the byte packer at the encoder output.
- Accepts NAL payload bytes over a strobe/ready handshake and strips emulation-prevention bytes (00 00 03 → 00 00).
- Holds the stripped stream in an MSB-aligned bit window. A decoder-side parser peeks the window, consumes 0..SHOWBITS bits per cycle, and reads combinational Exp-Golomb ue(v)/se(v) results for the bits at the window head.

Parameters:
- WINBITS, 32, bit-window register width; must equal SHOWBITS+8.
- SHOWBITS, 24, visible peek width and maximum single advance.

Ports:
- CLK  input  1  clock; all state on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- NEWSLICE  input  1  synchronous flush of window, count, zero-run state and ERR.
- BYTE  input  8  payload byte.
- STROBE  input  1  BYTE valid; transfer occurs when STROBE&&READY.
- READY  output  1  byte acceptance; high iff AVAIL <= WINBITS-8 and NEWSLICE low.
- BITS  output  SHOWBITS  window head, MSB = next bit; bits beyond AVAIL read 0.
- AVAIL  output  6  number of valid bits in window (0..32).
- ADV  input  1  consume ADVL bits this cycle.
- ADVL  input  5  bits to consume (0..SHOWBITS).
- UEOK  output  1  a complete ue(v) codeword is present at the head.
- UEVAL  output  16  ue(v) codeNum.
- SEVAL  output  16  se(v) mapping of UEVAL, two's complement.
- UELEN  output  5  ue(v) codeword length = 2*lz+1.
- ERR  output  1  sticky; over-advance detected.

Behaviour:
- Reset (RESETN=0, async): window=0, AVAIL=0, zero-run zc=0, ERR=0. Resulting outputs: READY=1, BITS=0, UEOK=0, UEVAL=0, SEVAL=0, UELEN=1.
- READY is decoded from registered AVAIL only. It does not depend on same-cycle ADV.
- Emulation prevention, per accepted byte:
  - If zc==2 and BYTE==0x03: discard the byte, zc<=0, window unchanged.
  - Otherwise append the byte. zc <= (BYTE==0) ? min(zc+1,2) : 0.
  - After a discard, a following 0x03 is data: 00 00 03 03 yields 00 00 03.
  - zc persists across advances; it is cleared only by reset or NEWSLICE.
- Advance legality: ADV with ADVL<=AVAIL is legal. ADV with ADVL>AVAIL is ignored (no shift), ERR<=1, and any append in that same cycle still occurs.
- Update per cycle, with a = legal ADV ? ADVL : 0 and b = appended ? 8 : 0:
  - window_next = (window << a) | (BYTE << (WINBITS-8-(AVAIL-a))) when appending.
  - AVAIL_next = AVAIL - a + b.
  - Max AVAIL is 32 by the READY rule; no overflow is possible.
- Latency: a byte accepted in cycle t is visible in BITS/AVAIL at t+1. An advance in t is reflected at t+1.
- Exp-Golomb (combinational from registered window):
  - lz = leading zeros of BITS.
  - UEOK = (lz<=11) && (AVAIL >= 2*lz+1).
  - UEVAL = BITS[SHOWBITS-1-lz -: lz+1] - 1, zero-extended.
  - SEVAL = UEVAL odd ? (UEVAL+1)/2 : -(UEVAL/2).
  - When UEOK=0, UEVAL/SEVAL are don't-care but must not be X. The parser advances UELEN itself.
- NEWSLICE has priority over STROBE and ADV. Any byte presented that cycle is not accepted (READY=0). Next cycle the window is empty, zc=0, ERR=0.
- RESETN asserted mid-stream: immediate clear. No partial byte survives.

Test Plan:
- Plain stream: bytes A5,3C,FF → AVAIL=24, BITS=0xA53CFF, READY=1. One more byte 12 → AVAIL=32, READY=0.
- Emulation prevention: 00,00,03,01 → AVAIL=24, BITS=0x000001. Then 00,00,03,03 after NEWSLICE → BITS=0x000003 (second 03 kept).
- Exp-Golomb: bytes 28,00,00 → lz=2, UELEN=5, UEVAL=4, SEVAL=-2, UEOK=1. ADV 5 → BITS=0x000000, UEOK=0. Bytes 80,.. → UEVAL=0.
- Backpressure/simultaneity: fill to AVAIL=32. ADV=1, ADVL=8 → AVAIL=24, READY=1 next cycle. Then STROBE byte plus ADVL=4 in the same cycle → AVAIL=28, correct bit order.
- Over-advance: AVAIL=8, ADVL=12 → ERR=1 sticky, window/AVAIL unchanged. NEWSLICE → ERR=0, AVAIL=0.
- Async reset mid-stream at AVAIL=16, zc=2 → outputs at reset values immediately. Post-reset 03 is appended as data.
